// File: rtl/axis_qpsk_demod.sv
// axis_qpsk_demod
// Hard-decision QPSK demapper for one Hermitian-symmetric OFDM symbol per
// frame. Accepts FFT bins over AXI-Stream. Keeps data bins 1..NFFT/2-1,
// slices each bin to a 2-bit symbol and packs the symbols LSB-first into
// bytes. m_axis_tlast marks the last byte of each OFDM symbol.
//
// Parameters:
//   NFFT            bins per OFDM symbol (power of 2, 8..1024)
//   LOWCONF_THRESH  magnitude threshold for the low-confidence counter
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axis_*        input bins: tdata[31:16]=Q, tdata[15:0]=I (signed)
//   m_axis_*        packed symbol bytes, first symbol in tdata[1:0]
//   sync_err        one-cycle pulse on inconsistent framing
//   lowconf_cnt     present only when QPSK_DEMOD_LOWCONF_EN is defined:
//                   saturating count of low-magnitude data bins in the
//                   OFDM symbol, updated when the tlast byte is loaded
//
// Optional feature macro: QPSK_DEMOD_LOWCONF_EN
module axis_qpsk_demod #(
  parameter int          NFFT           = 64,
  parameter logic [15:0] LOWCONF_THRESH = 16'd2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        sync_err
`ifdef QPSK_DEMOD_LOWCONF_EN
  , output logic [15:0] lowconf_cnt
`endif
);

  localparam int BW = $clog2(NFFT);
  localparam logic [BW-1:0] LAST_BIN  = BW'(NFFT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(NFFT / 2 - 1);

  logic [BW-1:0] bin_cnt;
  logic [1:0]    shift;
  logic [7:0]    acc;

  logic          accept;
  logic          is_data;
  logic          early_tlast;
  logic          missing_tlast;
  logic          frame_end;
  logic          pending;
  logic          emit;
  logic          emit_last;
  logic [1:0]    sym;
  logic [7:0]    acc_next;

  // Only the sign bits drive the decision in the default build.
  logic          data_unused;
  assign data_unused = ^{s_axis_tdata, LOWCONF_THRESH};

  // Single output register: a new byte can load whenever the held one is
  // empty or leaving this cycle, so completing bins never see a bubble.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;

  always_comb begin
    accept        = s_axis_tvalid && s_axis_tready;
    is_data       = (bin_cnt != '0) && (bin_cnt <= LAST_DATA);
    early_tlast   = s_axis_tlast && (bin_cnt != LAST_BIN);
    missing_tlast = !s_axis_tlast && (bin_cnt == LAST_BIN);
    frame_end     = s_axis_tlast || (bin_cnt == LAST_BIN);
    // Zero is positive, so the sign bit alone gives the decision.
    sym           = {s_axis_tdata[15], s_axis_tdata[31]};
    acc_next      = acc;
    if (is_data) begin
      acc_next[{shift, 1'b0} +: 2] = sym;
    end
    pending   = is_data || (shift != 2'd0);
    // A byte leaves on a full accumulator, on the last data bin, or when an
    // early tlast has to flush a partial byte.
    emit      = accept && ((is_data && ((shift == 2'd3) || (bin_cnt == LAST_DATA)))
                           || (early_tlast && pending));
    emit_last = (bin_cnt == LAST_DATA) || early_tlast;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt       <= '0;
      shift         <= '0;
      acc           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= acc_next;
        m_axis_tlast  <= emit_last;
      end
      sync_err <= accept && (early_tlast || missing_tlast);
      if (accept) begin
        bin_cnt <= frame_end ? '0 : bin_cnt + BW'(1);
        if (emit) begin
          shift <= '0;
          acc   <= '0;
        end else if (is_data) begin
          shift <= shift + 2'd1;
          acc   <= acc_next;
        end
      end
    end
  end

`ifdef QPSK_DEMOD_LOWCONF_EN
  logic [15:0] run_cnt;
  logic [15:0] run_sum;
  logic        low;

  function automatic logic [15:0] mag(input logic [15:0] x);
    if (x == 16'h8000) begin
      return 16'h7FFF;
    end else if (x[15]) begin
      return 16'd0 - x;
    end else begin
      return x;
    end
  endfunction

  always_comb begin
    low     = (mag(s_axis_tdata[15:0]) < LOWCONF_THRESH)
           || (mag(s_axis_tdata[31:16]) < LOWCONF_THRESH);
    run_sum = run_cnt;
    if (is_data && low && (run_cnt != 16'hFFFF)) begin
      run_sum = run_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt     <= '0;
      lowconf_cnt <= '0;
    end else if (accept) begin
      if (emit && emit_last) begin
        lowconf_cnt <= run_sum;
        run_cnt     <= '0;
      end else if (frame_end) begin
        run_cnt <= '0;
      end else begin
        run_cnt <= run_sum;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_qpsk_demod.sv
// Testbench for axis_qpsk_demod (NFFT=64). Expected bytes are pushed to a
// scoreboard queue as stimulus is driven and compared as the DUT emits them.
module tb_axis_qpsk_demod;

  localparam int NFFT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        sync_err;
`ifdef QPSK_DEMOD_LOWCONF_EN
  logic [15:0] lowconf_cnt;
`endif

  always #5 clk = ~clk;

  axis_qpsk_demod #(.NFFT(NFFT)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tlast  (s_last),
    .m_axis_tdata  (m_data),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tlast  (m_last),
    .sync_err      (sync_err)
`ifdef QPSK_DEMOD_LOWCONF_EN
    , .lowconf_cnt (lowconf_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [15:0] i;
    logic [15:0] q;
    logic [1:0]  sym;
  } dec_vec_t;

  exp_t     sb[$];
  dec_vec_t dvec[6];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   sync_cnt = 0;
  bit   rand_mode = 1'b0;
  logic ready_val = 1'b1;

  logic       prev_stall = 1'b0;
  logic       prev_sync  = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream ready: fixed level or ~50% random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Output monitor: sampled on the falling edge, between active edges.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_sync  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_tvalid", m_valid, 1);
          check("hold_tdata_tlast", {m_data, m_last}, {prev_data, prev_last});
        end
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h last %0b, expected none", m_data, m_last);
          end else begin
            e = sb.pop_front();
            check("byte", {m_data, m_last}, {e.data, e.last});
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (sync_err) begin
          sync_cnt++;
          if (prev_sync) begin
            n_checks++;
            n_fail++;
            $display("FAIL sync_err_width: got >1 cycle, expected 1 cycle");
          end
        end
        prev_sync = sync_err;
      end
    end
  end

  task automatic drive_beat(input logic [15:0] i, input logic [15:0] q, input logic last);
    int budget = 0;
    s_data  = {q, i};
    s_last  = last;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready) begin
      budget++;
      if (budget > 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL beat_accept: got no tready in 1000 cycles, expected tready");
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Bins 1..31 cycle through symbols 0,1,2,3; other bins are positive.
  function automatic logic [31:0] pat(input int unsigned b, input logic [15:0] mag);
    logic [1:0]  s;
    logic [15:0] p;
    logic [15:0] n;
    p = mag;
    n = 16'd0 - mag;
    if (b == 0 || b >= NFFT / 2) return {p, p};
    s = 2'((b - 1) % 4);
    return {(s[0] ? n : p), (s[1] ? n : p)};
  endfunction

  task automatic send_symbol(input logic with_tlast, input int unsigned lc_bins);
    logic [31:0] v;
    for (int k = 0; k < 7; k++) sb.push_back('{data: 8'hE4, last: 1'b0});
    sb.push_back('{data: 8'h24, last: 1'b1});
    for (int unsigned b = 0; b < NFFT; b++) begin
      v = pat(b, (b >= 1 && b <= lc_bins) ? 16'd100 : 16'd11520);
      drive_beat(v[15:0], v[31:16], with_tlast && (b == NFFT - 1));
    end
  endtask

  task automatic drain(input string name, input int sync_before, input int exp_sync);
    int budget = 0;
    while (sb.size() != 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_drain"}, sb.size(), 0);
    check({name, "_sync_err"}, sync_cnt - sync_before, exp_sync);
    sb.delete();
  endtask

  initial begin
    int s0;
    logic [31:0] v;

    dvec[0] = '{i: 16'h0000, q: 16'h0000, sym: 2'd0};
    dvec[1] = '{i: 16'hFFFF, q: 16'h0000, sym: 2'd2};
    dvec[2] = '{i: 16'h0000, q: 16'hFFFF, sym: 2'd1};
    dvec[3] = '{i: 16'h8000, q: 16'h7FFF, sym: 2'd2};
    dvec[4] = '{i: 16'h7FFF, q: 16'h8000, sym: 2'd1};
    dvec[5] = '{i: 16'hFFFF, q: 16'hFFFF, sym: 2'd3};

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_valid, 0);
    check("rst_tdata", m_data, 0);
    check("rst_tlast", m_last, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_tready", s_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Clean symbol, ready held high.
    s0 = sync_cnt;
    send_symbol(1'b1, 0);
    idle();
    drain("clean", s0, 0);
`ifdef QPSK_DEMOD_LOWCONF_EN
    check("lowconf_clean", lowconf_cnt, 0);
`endif

    // Back-to-back symbols with random backpressure.
    rand_mode = 1'b1;
    s0 = sync_cnt;
    for (int k = 0; k < 3; k++) send_symbol(1'b1, 0);
    idle();
    drain("backpressure", s0, 0);
    rand_mode = 1'b0;

    // Decision table: each vector sits on bin 1 with an early tlast, so it
    // comes out alone in a flushed tlast byte.
    s0 = sync_cnt;
    foreach (dvec[n]) begin
      sb.push_back('{data: {6'd0, dvec[n].sym}, last: 1'b1});
      drive_beat(16'd11520, 16'd11520, 1'b0);
      drive_beat(dvec[n].i, dvec[n].q, 1'b1);
    end
    idle();
    drain("decision", s0, 6);

    // Early tlast on the tenth beat (bin index 9): nine symbols of 3.
    s0 = sync_cnt;
    sb.push_back('{data: 8'hFF, last: 1'b0});
    sb.push_back('{data: 8'hFF, last: 1'b0});
    sb.push_back('{data: 8'h03, last: 1'b1});
    for (int b = 0; b < 10; b++) drive_beat(16'hD300, 16'hD300, b == 9);
    send_symbol(1'b1, 0);
    idle();
    drain("early_tlast", s0, 1);

    // tlast on bin 0 is early; nothing pending, so no byte.
    s0 = sync_cnt;
    drive_beat(16'd11520, 16'd11520, 1'b1);
    send_symbol(1'b1, 0);
    idle();
    drain("tlast_bin0", s0, 1);

    // Symbol with tlast missing on bin 63, then a normal one.
    s0 = sync_cnt;
    send_symbol(1'b0, 0);
    send_symbol(1'b1, 0);
    idle();
    drain("missing_tlast", s0, 1);

    // Reset mid-stream: first with a partial accumulator, then with a held
    // output byte. Neither may produce output afterwards.
    s0 = sync_cnt;
    for (int b = 0; b < 3; b++) drive_beat(16'hD300, 16'hD300, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned b = 0; b < 5; b++) begin
      v = pat(b, 16'd11520);
      drive_beat(v[15:0], v[31:16], 1'b0);
    end
    idle();
    @(negedge clk);
    check("held_byte_tvalid", m_valid, 1);
    check("held_byte_tdata", m_data, 8'hE4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tvalid", m_valid, 0);
    ready_val = 1'b1;
    @(posedge clk);
    #1;
    send_symbol(1'b1, 0);
    idle();
    drain("mid_reset", s0, 0);

`ifdef QPSK_DEMOD_LOWCONF_EN
    s0 = sync_cnt;
    send_symbol(1'b1, 5);
    idle();
    drain("lowconf", s0, 0);
    check("lowconf_cnt", lowconf_cnt, 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
